// File: rtl/uptimer.sv
// uptimer: count-up elapsed-time timer with prescaler, sticky compare-match and overflow flags.
// Define UPTIMER_CAPTURE_EN to add the synchronised evt timestamp capture; otherwise capture/captured read 0.
module uptimer #(
    parameter int unsigned PERIOD = 1000,
    parameter int unsigned WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             cmp_load,
    input  logic [WIDTH-1:0] cmp_data,
    input  logic             evt,
    output logic [WIDTH-1:0] counter,
    output logic             running,
    output logic             match,
    output logic             overflow,
    output logic [WIDTH-1:0] capture,
    output logic             captured
);

    typedef enum logic [1:0] {IDLE, RUN, OVF} state_t;

    localparam logic [WIDTH-1:0] ALL1 = '1;

    state_t           state;
    logic [15:0]      prescaler;
    logic [WIDTH-1:0] cmp;
    logic [16:0]      inc;
    logic             tick_due;
    logic [WIDTH-1:0] nxt;

    // 17-bit compare so PERIOD=0 and PERIOD=1 both tick every clock
    assign inc      = {1'b0, prescaler} + 17'd1;
    assign tick_due = (inc >= 17'(PERIOD));
    assign nxt      = counter + WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            running   <= 1'b0;
            counter   <= '0;
            prescaler <= '0;
            cmp       <= '0;
            match     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (clear) begin
                counter   <= '0;
                prescaler <= '0;
                match     <= 1'b0;
                overflow  <= 1'b0;
                if (state == OVF || (state == RUN && stop)) begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            // prescaler is held so a resume finishes the partial period
                            state   <= IDLE;
                            running <= 1'b0;
                        end else if (tick_due) begin
                            prescaler <= '0;
                            if (counter != ALL1) begin
                                counter <= nxt;
                                if (nxt == cmp) match <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                                state    <= OVF;
                                running  <= 1'b0;
                            end
                        end else begin
                            prescaler <= inc[15:0];
                        end
                    end
                    default: ;
                endcase
            end
            // a coinciding tick above already compared against the old cmp
            if (cmp_load) cmp <= cmp_data;
        end
    end

`ifdef UPTIMER_CAPTURE_EN
    logic [2:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= '0;
            capture  <= '0;
            captured <= 1'b0;
        end else begin
            sync <= {sync[1:0], evt};
            // an edge beats a simultaneous clear for the capture pair
            if (sync[1] && !sync[2]) begin
                capture  <= counter;
                captured <= 1'b1;
            end else if (clear) begin
                capture  <= '0;
                captured <= 1'b0;
            end
        end
    end
`else
    logic unused_evt;
    assign unused_evt = evt;
    assign capture    = '0;
    assign captured   = 1'b0;
`endif

endmodule

// File: tb/tb_uptimer.sv
// Randomised scoreboard bench for uptimer: a behavioural model queues expected outputs per clock,
// a monitor pops and compares after each rising edge; directed plan checks use fixed constants.
module tb_uptimer;
    localparam int P    = 4;
    localparam int W    = 5;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0, stop = 1'b0, clear = 1'b0, cmp_load = 1'b0, evt = 1'b0;
    logic [W-1:0] cmp_data = '0;
    logic [W-1:0] counter, capture;
    logic         running, match, overflow, captured;

    uptimer #(.PERIOD(P), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .cmp_load(cmp_load), .cmp_data(cmp_data), .evt(evt),
        .counter(counter), .running(running), .match(match), .overflow(overflow),
        .capture(capture), .captured(captured)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit run;
        bit mt;
        bit ov;
        int cap;
        bit capd;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // behavioural model: mode 0 stopped, 1 counting, 2 halted after overflow
    int m_mode, m_cnt, m_pre, m_cmp, m_cap;
    bit m_mt, m_ov, m_capd;
    bit e_hist[3];   // evt as seen at the last three clock edges, newest first

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit st, input bit sp, input bit cl,
                         input bit ld, input int d, input bit e);
        int old;
        bit det;
        if (r) begin
            m_mode = 0; m_cnt = 0; m_pre = 0; m_cmp = 0; m_cap = 0;
            m_mt = 0; m_ov = 0; m_capd = 0;
            e_hist = '{0, 0, 0};
        end else begin
            det = e_hist[1] && !e_hist[2];
            e_hist[2] = e_hist[1];
            e_hist[1] = e_hist[0];
            e_hist[0] = e;
            old = m_cnt;
            if (cl) begin
                m_cnt = 0; m_pre = 0; m_mt = 0; m_ov = 0; m_cap = 0; m_capd = 0;
                if (m_mode == 2 || (m_mode == 1 && sp)) m_mode = 0;
            end else if (m_mode == 1) begin
                if (sp) m_mode = 0;
                else if (m_pre + 1 >= P) begin
                    m_pre = 0;
                    if (m_cnt < MAXV) begin
                        m_cnt++;
                        if (m_cnt == m_cmp) m_mt = 1;
                    end else begin
                        m_ov = 1;
                        m_mode = 2;
                    end
                end else m_pre++;
            end else if (m_mode == 0 && st && !sp) m_mode = 1;
            if (ld) m_cmp = d;
`ifdef UPTIMER_CAPTURE_EN
            if (det) begin
                m_cap = old;
                m_capd = 1;
            end
`else
            if (det) m_capd = 0;
`endif
        end
    endtask

    // drive one clock's worth of inputs at the falling edge and queue what the next rising edge must show
    task automatic step(input bit r, input bit st, input bit sp, input bit cl,
                        input bit ld, input int d, input bit e);
        exp_t x;
        @(negedge clk);
        rst = r; start = st; stop = sp; clear = cl; cmp_load = ld;
        cmp_data = W'(d); evt = e;
        model(r, st, sp, cl, ld, d & MAXV, e);
        x.cnt = m_cnt; x.run = (m_mode == 1); x.mt = m_mt; x.ov = m_ov;
        x.cap = m_cap; x.capd = m_capd;
        sbq.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, evt);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb counter",  int'(counter),  e.cnt);
                chk("sb running",  int'(running),  int'(e.run));
                chk("sb match",    int'(match),    int'(e.mt));
                chk("sb overflow", int'(overflow), int'(e.ov));
                chk("sb capture",  int'(capture),  e.cap);
                chk("sb captured", int'(captured), int'(e.capd));
            end
        end
    end

    initial begin : driver
        bit st, sp, cl, ld, r, e;
        int d;

        step(1, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reset counter", int'(counter), 0);
        chk("reset running", int'(running), 0);

        // count rate: PERIOD=4, 20 clocks after start gives 5
        step(0, 1, 0, 0, 0, 0, 0);
        idle(20);
        settle();
        chk("rate counter", int'(counter), 5);
        chk("rate running", int'(running), 1);
        chk("rate match", int'(match), 0);
        chk("rate overflow", int'(overflow), 0);

        // stop holds, resume continues the partial period
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(10);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(30);
        settle();
        chk("stop hold counter", int'(counter), 2);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        settle();
        chk("resume counter", int'(counter), 3);

        // saturate and overflow
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle((MAXV + 1) * P);
        settle();
        chk("ovf flag", int'(overflow), 1);
        chk("ovf running", int'(running), 0);
        chk("ovf counter", int'(counter), MAXV);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(3);
        settle();
        chk("ovf start ignored", int'(running), 0);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(2);
        settle();
        chk("ovf clear counter", int'(counter), 0);
        chk("ovf clear flag", int'(overflow), 0);
        chk("ovf clear idle", int'(running), 0);

        // compare match
        step(0, 0, 0, 0, 1, 3, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(3 * P);
        settle();
        chk("match at 3", int'(match), 1);
        idle(P);
        settle();
        chk("match sticky", int'(match), 1);
        step(0, 0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        settle();
        chk("match clear", int'(match), 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle(3);
        settle();
        chk("load equal no match", int'(match), 0);

        // strobe priority
        step(0, 1, 1, 0, 0, 0, 0);
        settle();
        chk("start+stop idle", int'(running), 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(6);
        step(0, 0, 1, 1, 0, 0, 0);
        settle();
        chk("clear+stop counter", int'(counter), 0);
        chk("clear+stop running", int'(running), 0);

        // event capture: evt first seen high while counter=1
        step(0, 1, 0, 0, 0, 0, 0);
        idle(5);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
        settle();
`ifdef UPTIMER_CAPTURE_EN
        chk("captured", int'(captured), 1);
        chk("capture value", int'(capture), 1);
`else
        chk("captured off", int'(captured), 0);
        chk("capture off", int'(capture), 0);
`endif

        // randomised traffic
        e = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 999) < 3);
            st = ($urandom_range(0, 99) < 12);
            sp = ($urandom_range(0, 99) < 4);
            cl = ($urandom_range(0, 999) < 5);
            ld = ($urandom_range(0, 99) < 6);
            d  = ($urandom_range(0, 1) == 1) ? ((m_cnt + int'($urandom_range(0, 3))) & MAXV)
                                             : int'($urandom_range(0, MAXV));
            if ($urandom_range(0, 99) < 15) e = !e;
            step(r, st, sp, cl, ld, d, e);
        end

        step(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        chk("scoreboard drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uptimer.md
Name: uptimer

Overview:
Count-up (elapsed-time) timer, the measuring counterpart of the countdown timer.
- Software starts, stops and clears it through MMIO strobes.
- It counts up once every PERIOD clocks, saturates at all-ones, and raises sticky compare-match and overflow flags.
- It sits beside the countdown timer on the CPU's I/O bus and measures intervals and the timestamps of external events.

Parameters:
- PERIOD, 1000: clocks per count tick, 0..65535; 0 and 1 both mean a tick every clock.
- WIDTH, 16: counter, compare and capture width.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-clock strobe: begin or resume counting
- stop  input  1  one-clock strobe: pause counting, holding the counter value
- clear  input  1  one-clock strobe: zero counter, prescaler and all flags
- cmp_load  input  1  latch cmp_data into the compare register
- cmp_data  input  WIDTH  compare value
- evt  input  1  asynchronous external event, capture on rising edge
- counter  output  WIDTH  current count
- running  output  1  1 while in RUN
- match  output  1  sticky: counter reached the compare value
- overflow  output  1  sticky: a tick occurred while counter = all-ones
- capture  output  WIDTH  counter value latched at the last evt edge
- captured  output  1  sticky: capture holds a valid value

Behaviour:
- Clocking: one clock, clk; reset rst is asynchronous and active-high.
- Reset: counter, prescaler, cmp, capture = 0; running, match, overflow, captured = 0; state IDLE; synchroniser FFs = 0.
- States:
  - IDLE: stopped.
  - RUN: counting.
  - OVF: halted after overflow.
- Transitions:
  - IDLE --start--> RUN
  - RUN --stop--> IDLE
  - RUN --overflow tick--> OVF
  - any --clear--> state unchanged, except OVF --clear--> IDLE
- Strobe priority in one cycle: clear > stop > start. Simultaneous stop and start means stop wins.
- start has no effect in RUN or OVF. OVF is left only by clear or rst.
- clear in RUN: counter = 0, prescaler = 0, match/overflow/captured = 0, capture = 0, and the timer stays in RUN.
- stop keeps the prescaler value. Resume continues the partial period; it does not restart it.
- Prescaler, 16-bit, RUN only:
  - Let inc = prescaler + 1.
  - If inc < PERIOD: prescaler <= inc.
  - Otherwise: prescaler <= 0 and a tick occurs in this cycle.
- First tick after start from a cleared state comes PERIOD clocks after the start edge (1 clock if PERIOD ≤ 1).
- Tick:
  - If counter < all-ones: counter <= counter + 1.
  - Else: counter holds, overflow <= 1, state <= OVF, running <= 0.
- match is set in the cycle the counter is updated to a new value equal to cmp.
  - Loading cmp equal to the current counter does not set match.
  - match stays set until clear or rst.
- cmp_load is accepted in any state, in the same clock as the strobe. If cmp_load and a tick coincide, the tick compares against the old cmp.
- running is registered and equals (state == RUN).
- clear with no other activity returns every flag to 0 in the next cycle.

Optional Feature:
UPTIMER_CAPTURE_EN.
- Defined:
  - evt passes through a 2-FF synchroniser, then rising-edge detection against a third FF.
  - On a detected edge: capture <= counter (value at that clock) and captured <= 1.
  - evt high sampled at clock edge n gives capture/captured visible after edge n+2.
  - Works in every state.
  - An edge that coincides with clear still captures, because capture has priority over clear for capture/captured only.
  - A new edge overwrites capture.
- Undefined: no synchroniser logic; capture = 0 and captured = 0 constantly; evt is ignored.

Test Plan:
- PERIOD=4. rst, start pulse, wait 20 clocks → counter=5, running=1, match=0, overflow=0.
- PERIOD=4. start, run 10 clocks, stop, idle 30 clocks → counter=2 and held. Then start, 2 more clocks → counter=3, confirming prescaler resume.
- PERIOD=1, WIDTH=4. start, 16 clocks → counter=15. 1 more clock → overflow=1, running=0, counter=15. start pulse → no change. clear → counter=0, overflow=0, state IDLE.
- PERIOD=2. cmp_load with cmp_data=3, start; at counter=3 → match=1. Counter continues to 4, match stays 1. cmp_load cmp_data=4 (equal to counter) → no new match event; clear → match=0.
- start and stop in the same cycle from IDLE → running stays 0. clear and stop together while running → counter=0, running=0.
- UPTIMER_CAPTURE_EN, PERIOD=1. start, raise evt asynchronously mid-cycle when counter ≈ 7 → captured=1 and capture within 1 of 9 (2-3 clock latency). Build without the macro → capture=0, captured=0.
